// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard bus: ID/EX/MEM hazard observations in, advance/stall/flush controls out.
// The controller connects through the slave modport; the pipeline datapath uses the master modport.
interface hazard_stall_controller_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic [4:0] id_ex_rd;
  logic       id_ex_mem_read;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_write;
  logic       if_id_write;
  logic       pipe_hold;
  logic       id_ex_bubble;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       flush_ex_mem;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, id_ex_rd, id_ex_mem_read,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, pipe_hold, id_ex_bubble,
           flush_if_id, flush_id_ex, flush_ex_mem
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, id_ex_rd, id_ex_mem_read,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, pipe_hold, id_ex_bubble,
           flush_if_id, flush_id_ex, flush_ex_mem
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Central sequencer for the 5-stage core: load-use interlock, taken-branch flush and
// data-memory freeze, with saturating stall/flush statistics and a sticky memory timeout flag.
module hazard_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_stall_controller_if.slave pipe,
  output logic                     mem_timeout_err,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         flush_events
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_MAX   = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_ev_q, flush_ev_d;

  logic mem_stall;
  logic load_use;
  logic flush_ev_inc;
  logic pc_write, if_id_write, pipe_hold, id_ex_bubble;
  logic flush_if_id, flush_id_ex, flush_ex_mem;

  assign mem_stall = pipe.dmem_req & ~pipe.dmem_ready;
  assign load_use  = pipe.id_ex_mem_read && (pipe.id_ex_rd != 5'd0) &&
                     ((pipe.id_ex_rd == pipe.id_rs1) ||
                      (pipe.id_uses_rs2 && (pipe.id_ex_rd == pipe.id_rs2)));

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    flush_ev_inc = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pipe_hold    = 1'b0;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          state_d     = MEM_WAIT;
          wait_cnt_d  = WC_W'(1);
        end else if (pipe.branch_taken) begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_ev_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        // A memory freeze pauses the flush; the remaining count survives the wait.
        if (mem_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          state_d     = MEM_WAIT;
          wait_cnt_d  = WC_W'(1);
        end else begin
          flush_if_id = 1'b1;
          flush_cnt_d = flush_cnt_q - FC_W'(1);
          if (flush_cnt_q <= FC_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q == WAIT_MAX) begin
          err_d = 1'b1;
        end
        if (pipe.dmem_ready) begin
          wait_cnt_d = '0;
          state_d    = (flush_cnt_q != '0) ? FLUSH : RUN;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    stall_d    = (!pc_write && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_ev_d = (flush_ev_inc && (flush_ev_q != '1)) ? flush_ev_q + CNT_W'(1) : flush_ev_q;

    // Under reset the pipeline must see plain advance, whatever the hazard inputs say.
    if (reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      pipe_hold    = 1'b0;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
      flush_ev_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      flush_ev_q  <= flush_ev_d;
    end
  end

  assign pipe.pc_write     = pc_write;
  assign pipe.if_id_write  = if_id_write;
  assign pipe.pipe_hold    = pipe_hold;
  assign pipe.id_ex_bubble = id_ex_bubble;
  assign pipe.flush_if_id  = flush_if_id;
  assign pipe.flush_id_ex  = flush_id_ex;
  assign pipe.flush_ex_mem = flush_ex_mem;

  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;
  assign flush_events    = flush_ev_q;

endmodule
